inst_parser_q: RTL and testbench
================================

# inst_parser_q

Parametrised successor to the renderer's instruction parser: decodes instruction words into render commands and adds what the single-cycle parser lacks. It adds valid/ready handshakes on both sides, two-word wide instructions, illegal-opcode flagging and a DEPTH-entry decoded-instruction queue. It sits between instruction fetch and the camera/light/shape register-update stage, which drains it via `out_ready`.

## Interface
- `IDX_W`, 8: index field width (light or shape index)
- `PROP_W`, 5: property field width
- `DATA_W`, 16: data field width
- `PC_W`, 16: instruction address width
- `DEPTH`, 4: output queue entries; power of 2, ≥2
- Derived `INST_W = OP_W + IDX_W + PROP_W + DATA_W` (32 at defaults)

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous clear of queue and assembly state
- `in_valid`  in  1  `instruction`/`pc_in` valid
- `in_ready`  out  1  word accepted when `in_valid && in_ready`
- `pc_in`  in  PC_W  address of the word
- `instruction`  in  INST_W  raw word
- `out_valid`  out  1  queue head valid
- `out_ready`  in  1  consumer pops head when `out_valid && out_ready`
- `out_itype`  out  OP_W  decoded instruction type
- `out_index`  out  IDX_W  light/shape index
- `out_prop`, `out_prop2`  out  PROP_W  properties
- `out_data`, `out_data2`  out  DATA_W  data words
- `out_pc`  out  PC_W  pc of the first word of the instruction
- `out_illegal`  out  1  malformed instruction
- `count`  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Word fields:
  - `[OP_W-1:0]` op
  - `[OP_W +: IDX_W]` index
  - `[OP_W+IDX_W +: PROP_W]` prop
  - `[INST_W-1 -: DATA_W]` data
- Ops:
  - 000 CTRL: index 0 = new render, 1 = new frame
  - 001 CAM
  - 010 LIGHT
  - 011 SHAPE
  - 100 SHAPE_WIDE
  - 101 LIGHT_WIDE
  - 110 illegal
  - 111 CONT: continuation marker, illegal as a first word
- Single-word ops and illegal ops push one entry on acceptance.
  - prop2/data2 = 0.
  - Illegal entries carry their raw fields with `out_illegal = 1`.
- FSM `FIRST` / `SECOND`:
  - FIRST + accepted wide op: latch fields and pc, go to SECOND, no push.
  - SECOND + accepted word with op CONT: push one entry, then go to FIRST.
    - Fields come from the latched first word.
    - prop2/data2 come from the second word's prop/data fields.
  - SECOND + accepted word with any other op: push the latched first word with `out_illegal = 1`, drop the second word, go to FIRST.
- `in_ready = (count < DEPTH)`, regardless of FSM state; no full-queue bypass.
- All out_* fields are 0 while `out_valid = 0`.

## Timing
- Reset values: `count = 0`, FSM = FIRST, `out_valid = 0`, all out_* fields = 0, `in_ready = 1`.
- Latency: an entry pushed at edge N is visible with `out_valid = 1` after edge N (1 cycle from final-word acceptance).
- Push and pop in the same cycle: count unchanged.
- Full with `out_ready = 1`: pop happens, but `in_ready` was already 0 that cycle, so no push.
- Pointers wrap modulo DEPTH; entries are delivered strictly in order.
- `flush` takes priority over push and pop in the same cycle: count = 0, FSM = FIRST, latched word discarded.
- `rst` asserted mid-wide-instruction discards the latched word with no output.
- The consumer may hold `out_ready` low indefinitely; the head entry stays stable until popped.

## Structure
- Package `proctypes`: `OP_W = 3`, `OpCode` enum (CTRL, CAM, LIGHT, SHAPE, SHAPE_WIDE, LIGHT_WIDE, ILL, CONT), CTRL index constants.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`: queue storage, pointers and count; the FSM and decode stay in `inst_parser_q`.

## Test plan
- Reset release → `out_valid = 0`, `in_ready = 1`, `count = 0`, all out_* fields 0.
- 32'h555F0801 → next cycle: CAM, index 0, prop 1, data 0x555F, prop2/data2 0, illegal 0.
- 32'h1234101C then 32'hABCD2807 → nothing after word 1; one entry after word 2: SHAPE_WIDE, index 3, prop 2, data 0x1234, prop2 5, data2 0xABCD, pc of word 1.
- `out_ready = 0`, five CTRL words (index 0–4) offered → `in_ready` falls after the 4th, 5th held; pop one → 5th accepted; indices drained in order 0–4.
- 32'h00000006 → entry with `out_illegal = 1`. 32'h1234101C then 32'h00000001 → single illegal entry with word-1 fields, no CAM entry.
- 32'h1234101C, then `flush`, then 32'h555F0801 → only the CAM entry emerges, `count = 1`; repeat with `rst` instead of `flush` → same result.

Source files
------------

// File: rtl/proctypes.sv
// Shared decode types for the instruction parser: opcode encoding and
// CTRL-op index meanings.
package proctypes;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    CTRL       = 3'd0,
    CAM        = 3'd1,
    LIGHT      = 3'd2,
    SHAPE      = 3'd3,
    SHAPE_WIDE = 3'd4,
    LIGHT_WIDE = 3'd5,
    ILL        = 3'd6,
    CONT       = 3'd7
  } OpCode;

  // Meaning of the index field on a CTRL op
  typedef enum int unsigned {
    CTRL_NEW_RENDER = 0,
    CTRL_NEW_FRAME  = 1
  } ctrl_idx_e;

  // Wide ops take a CONT word as their second half
  function automatic logic is_wide(input logic [OP_W-1:0] op);
    return (op == SHAPE_WIDE) || (op == LIGHT_WIDE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: DEPTH entries of WIDTH bits, wrap-around pointers and
// occupancy count. Caller never pushes when full nor pops when empty.
//   clk, rst     clock, async active-high reset
//   flush        synchronous clear of pointers and count (wins over push/pop)
//   push, wdata  write one entry
//   pop          retire the head entry
//   rdata        head entry (contents undefined while empty)
//   count        occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/inst_parser_q.sv
// Instruction parser with handshakes, two-word wide instructions, illegal
// flagging and a decoded-instruction output queue.
//   clk, rst, flush                    clock, async reset, sync clear
//   in_valid/in_ready, pc_in,
//   instruction                        fetch-side handshake and word
//   out_valid/out_ready, out_*         consumer-side head of queue
//   count                              queue occupancy
module inst_parser_q
  import proctypes::*;
#(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned PROP_W = 5,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [PC_W-1:0]                        pc_in,
  input  logic [OP_W+IDX_W+PROP_W+DATA_W-1:0]    instruction,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OP_W-1:0]                        out_itype,
  output logic [IDX_W-1:0]                       out_index,
  output logic [PROP_W-1:0]                      out_prop,
  output logic [PROP_W-1:0]                      out_prop2,
  output logic [DATA_W-1:0]                      out_data,
  output logic [DATA_W-1:0]                      out_data2,
  output logic [PC_W-1:0]                        out_pc,
  output logic                                   out_illegal,
  output logic [$clog2(DEPTH):0]                 count
);

  localparam int unsigned INST_W = OP_W + IDX_W + PROP_W + DATA_W;
  localparam int unsigned ENT_W  = OP_W + IDX_W + 2*PROP_W + 2*DATA_W + PC_W + 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  typedef enum logic {FIRST, SECOND} state_e;

  state_e            state, state_nxt;
  logic [INST_W-1:0] lat_word;
  logic [PC_W-1:0]   lat_pc;
  logic              lat_load;
  logic              accept;
  logic              push;
  logic              pop;

  // Field views of the incoming and latched words
  logic [OP_W-1:0]   in_op,   lat_op;
  logic [IDX_W-1:0]  in_idx,  lat_idx;
  logic [PROP_W-1:0] in_prop, lat_prop;
  logic [DATA_W-1:0] in_data, lat_data;

  assign in_op    = instruction[OP_W-1:0];
  assign in_idx   = instruction[OP_W +: IDX_W];
  assign in_prop  = instruction[OP_W+IDX_W +: PROP_W];
  assign in_data  = instruction[INST_W-1 -: DATA_W];
  assign lat_op   = lat_word[OP_W-1:0];
  assign lat_idx  = lat_word[OP_W +: IDX_W];
  assign lat_prop = lat_word[OP_W+IDX_W +: PROP_W];
  assign lat_data = lat_word[INST_W-1 -: DATA_W];

  // Entry being pushed this cycle
  logic [OP_W-1:0]   e_itype;
  logic [IDX_W-1:0]  e_idx;
  logic [PROP_W-1:0] e_prop, e_prop2;
  logic [DATA_W-1:0] e_data, e_data2;
  logic [PC_W-1:0]   e_pc;
  logic              e_ill;
  logic [ENT_W-1:0]  wdata, rdata;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // State and first-word latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FIRST;
      lat_word <= '0;
      lat_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (lat_load) begin
        lat_word <= instruction;
        lat_pc   <= pc_in;
      end
    end
  end

  // Next state and entry assembly
  always_comb begin
    state_nxt = state;
    lat_load  = 1'b0;
    push      = 1'b0;
    e_itype   = '0;
    e_idx     = '0;
    e_prop    = '0;
    e_prop2   = '0;
    e_data    = '0;
    e_data2   = '0;
    e_pc      = '0;
    e_ill     = 1'b0;
    case (state)
      FIRST: begin
        if (accept) begin
          if (is_wide(in_op)) begin
            lat_load  = 1'b1;
            state_nxt = SECOND;
          end else begin
            push    = 1'b1;
            e_itype = in_op;
            e_idx   = in_idx;
            e_prop  = in_prop;
            e_data  = in_data;
            e_pc    = pc_in;
            e_ill   = (in_op == ILL) || (in_op == CONT);
          end
        end
      end
      SECOND: begin
        if (accept) begin
          // Second word is consumed either way; a non-CONT word poisons the pair
          push      = 1'b1;
          state_nxt = FIRST;
          e_itype   = lat_op;
          e_idx     = lat_idx;
          e_prop    = lat_prop;
          e_data    = lat_data;
          e_pc      = lat_pc;
          if (in_op == CONT) begin
            e_prop2 = in_prop;
            e_data2 = in_data;
          end else begin
            e_ill = 1'b1;
          end
        end
      end
      default: state_nxt = FIRST;
    endcase
    if (flush) begin
      state_nxt = FIRST;
      lat_load  = 1'b0;
      push      = 1'b0;
    end
  end

  assign wdata = {e_itype, e_idx, e_prop, e_data, e_prop2, e_data2, e_pc, e_ill};

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count)
  );

  // Head fields, forced to zero while the queue is empty
  logic [OP_W-1:0]   h_itype;
  logic [IDX_W-1:0]  h_idx;
  logic [PROP_W-1:0] h_prop, h_prop2;
  logic [DATA_W-1:0] h_data, h_data2;
  logic [PC_W-1:0]   h_pc;
  logic              h_ill;

  assign {h_itype, h_idx, h_prop, h_data, h_prop2, h_data2, h_pc, h_ill} = rdata;

  assign out_valid   = (count != '0);
  assign out_itype   = out_valid ? h_itype : '0;
  assign out_index   = out_valid ? h_idx   : '0;
  assign out_prop    = out_valid ? h_prop  : '0;
  assign out_prop2   = out_valid ? h_prop2 : '0;
  assign out_data    = out_valid ? h_data  : '0;
  assign out_data2   = out_valid ? h_data2 : '0;
  assign out_pc      = out_valid ? h_pc    : '0;
  assign out_illegal = out_valid && h_ill;

endmodule

// File: tb/tb_inst_parser_q.sv
// Directed bench for inst_parser_q at default parameters.
module tb_inst_parser_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pc_in;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_itype;
  logic [7:0]  out_index;
  logic [4:0]  out_prop, out_prop2;
  logic [15:0] out_data, out_data2;
  logic [15:0] out_pc;
  logic        out_illegal;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_parser_q dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pc_in       (pc_in),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_itype   (out_itype),
    .out_index   (out_index),
    .out_prop    (out_prop),
    .out_prop2   (out_prop2),
    .out_data    (out_data),
    .out_data2   (out_data2),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .count       (count)
  );

  logic [69:0] obs;
  assign obs = {out_itype, out_index, out_prop, out_data, out_prop2, out_data2, out_pc, out_illegal};

  function automatic logic [69:0] ent(input logic [2:0] t, input logic [7:0] i,
                                      input logic [4:0] p, input logic [15:0] d,
                                      input logic [4:0] p2, input logic [15:0] d2,
                                      input logic [15:0] pc, input logic ill);
    return {t, i, p, d, p2, d2, pc, ill};
  endfunction

  // Offer one word at a negedge, wait (bounded) for acceptance
  task automatic send(input logic [31:0] w, input logic [15:0] pc);
    int budget = 20;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed %b, needed 1", in_ready);
    end
    in_valid    = 1'b1;
    instruction = w;
    pc_in       = pc;
    @(negedge clk);
    in_valid    = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; instruction = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++;
    if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++;
    if (obs !== 70'd0) begin miscompares++; $display("FAIL reset_fields: got %h want 0", obs); end
  endtask

  task automatic test_single();
    logic [69:0] exp_e;
    send(32'h555F0801, 16'h0010);
    exp_e = ent(3'd1, 8'h00, 5'd1, 16'h555F, 5'd0, 16'h0, 16'h0010, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || count !== 3'd1) begin miscompares++; $display("FAIL single_valid: got v=%b c=%0d want v=1 c=1", out_valid, count); end
    vectors++;
    if (obs !== exp_e) begin miscompares++; $display("FAIL single_cam: got %h want %h", obs, exp_e); end
    pop_one();
    vectors++;
    if (out_valid !== 1'b0 || obs !== 70'd0) begin miscompares++; $display("FAIL single_drained: got v=%b f=%h want v=0 f=0", out_valid, obs); end
  endtask

  task automatic test_wide();
    logic [69:0] exp_e;
    send(32'h1234101C, 16'h0020);
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL wide_first_no_push: got v=%b c=%0d want v=0 c=0", out_valid, count); end
    send(32'hABCD2807, 16'h0021);
    exp_e = ent(3'd4, 8'h03, 5'd2, 16'h1234, 5'd5, 16'hABCD, 16'h0020, 1'b0);
    vectors++;
    if (count !== 3'd1) begin miscompares++; $display("FAIL wide_count: got %0d want 1", count); end
    vectors++;
    if (obs !== exp_e) begin miscompares++; $display("FAIL wide_entry: got %h want %h", obs, exp_e); end
    pop_one();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) send(32'(i) << 3, 16'(16'h0100 + i));
    vectors++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin miscompares++; $display("FAIL bp_full: got r=%b c=%0d want r=0 c=4", in_ready, count); end
    // Fifth word offered while full: must be held
    in_valid = 1'b1; instruction = 32'(4) << 3; pc_in = 16'h0104;
    @(negedge clk);
    vectors++;
    if (count !== 3'd4 || out_index !== 8'd0) begin miscompares++; $display("FAIL bp_held: got c=%0d head=%0d want c=4 head=0", count, out_index); end
    // Pop while full: pop only, then the held word goes in
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_pop_no_push: got c=%0d r=%b want c=3 r=1", count, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd4) begin miscompares++; $display("FAIL bp_fifth_accepted: got %0d want 4", count); end
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_itype !== 3'd0 || out_index !== 8'(i) || out_pc !== 16'(16'h0100 + i)) begin
        miscompares++;
        $display("FAIL bp_order_%0d: got v=%b t=%0d idx=%0d pc=%h want v=1 t=0 idx=%0d pc=%h",
                 i, out_valid, out_itype, out_index, out_pc, i, 16'(16'h0100 + i));
      end
      pop_one();
    end
    vectors++;
    if (count !== 3'd0) begin miscompares++; $display("FAIL bp_empty: got %0d want 0", count); end
  endtask

  task automatic test_illegal();
    logic [69:0] exp_e;
    send(32'h00000006, 16'h0030);
    exp_e = ent(3'd6, 8'h00, 5'd0, 16'h0, 5'd0, 16'h0, 16'h0030, 1'b1);
    vectors++;
    if (obs !== exp_e) begin miscompares++; $display("FAIL illegal_op: got %h want %h", obs, exp_e); end
    pop_one();
    send(32'h1234101C, 16'h0040);
    send(32'h00000001, 16'h0041);
    exp_e = ent(3'd4, 8'h03, 5'd2, 16'h1234, 5'd0, 16'h0, 16'h0040, 1'b1);
    vectors++;
    if (count !== 3'd1) begin miscompares++; $display("FAIL broken_wide_count: got %0d want 1", count); end
    vectors++;
    if (obs !== exp_e) begin miscompares++; $display("FAIL broken_wide_entry: got %h want %h", obs, exp_e); end
    pop_one();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL broken_wide_extra: got v=%b want 0", out_valid); end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [69:0] exp_e;
    send(32'h1234101C, 16'h0050);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    send(32'h555F0801, 16'h0051);
    exp_e = ent(3'd1, 8'h00, 5'd1, 16'h555F, 5'd0, 16'h0, 16'h0051, 1'b0);
    vectors++;
    if (count !== 3'd1) begin miscompares++; $display("FAIL abort_count(rst=%0d): got %0d want 1", use_rst, count); end
    vectors++;
    if (obs !== exp_e) begin miscompares++; $display("FAIL abort_entry(rst=%0d): got %h want %h", use_rst, obs, exp_e); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [69:0] exp_e;
    send(32'h555F0801, 16'h0060);
    // Push and pop in the same cycle
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h00AB0852; pc_in = 16'h0061;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    exp_e = ent(3'd2, 8'h0A, 5'd1, 16'h00AB, 5'd0, 16'h0, 16'h0061, 1'b0);
    vectors++;
    if (count !== 3'd1) begin miscompares++; $display("FAIL b2b_count: got %0d want 1", count); end
    vectors++;
    if (obs !== exp_e) begin miscompares++; $display("FAIL b2b_entry: got %h want %h", obs, exp_e); end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wide();
    test_backpressure();
    test_illegal();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
